// File: rtl/boreal_ledger_replay.sv
// Replays a range of 128-bit ledger entries from an MMIO slave onto a ready/valid stream.
// The committed count is read once per replay and the requested window is range-checked against it.
module boreal_ledger_replay #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          DEPTH_LOG = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  first_idx,
  input  logic [15:0]  num_entries,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err,
  output logic         m_sel,
  output logic         m_wr,
  output logic [31:0]  m_addr,
  output logic [31:0]  m_wdata,
  input  logic [31:0]  m_rdata,
  input  logic         m_ack,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic [31:0]  out_index,
  input  logic         out_ready
);

  localparam logic [31:0] ADDR_IDX = BASE_ADDR + 32'h00;
  localparam logic [31:0] ADDR_RDA = BASE_ADDR + 32'h08;
  localparam logic [31:0] ADDR_D0  = BASE_ADDR + 32'h0C;
  localparam logic [31:0] ADDR_D1  = BASE_ADDR + 32'h10;
  localparam logic [31:0] ADDR_D2  = BASE_ADDR + 32'h14;
  localparam logic [31:0] ADDR_D3  = BASE_ADDR + 32'h18;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_IDX, S_CHECK, S_SET_ADDR, S_WAIT,
    S_RD_W0, S_RD_W1, S_RD_W2, S_RD_W3, S_EMIT
  } state_t;

  state_t         state_q;
  logic [31:0]    idx_q;
  logic [15:0]    cnt_q;
  logic [31:0]    c_q;
  logic           abort_q;
  logic           done_q;
  logic [1:0]     err_q;
  logic           sel_q;
  logic           wr_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic           oval_q;
  logic [127:0]   odata_q;
  logic [31:0]    oidx_q;

  logic [32:0]    end_sum;
  logic           range_bad;
  logic [31:0]    idx_nxt;
  logic [31:0]    ring_cur;
  logic [31:0]    ring_nxt;
  logic           abort_now;

  // idx_q/cnt_q still hold first_idx/num_entries while in CHECK
  assign end_sum   = {1'b0, idx_q} + {17'b0, cnt_q};
  assign range_bad = (end_sum > {1'b0, c_q}) ||
                     ((c_q > DEPTH_U) && (idx_q < (c_q - DEPTH_U)));
  assign idx_nxt   = idx_q + 32'd1;
  assign ring_cur  = {{(32-DEPTH_LOG){1'b0}}, idx_q[DEPTH_LOG-1:0]};
  assign ring_nxt  = {{(32-DEPTH_LOG){1'b0}}, idx_nxt[DEPTH_LOG-1:0]};
  // An abort only takes effect once no MMIO transaction is left open
  assign abort_now = (abort | abort_q) & (~sel_q | m_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oval_q  <= 1'b0;
      odata_q <= '0;
      oidx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (sel_q && !m_ack && abort)
        abort_q <= 1'b1;
      if (state_q != S_IDLE && abort_now) begin
        state_q <= S_IDLE;
        abort_q <= 1'b0;
        sel_q   <= 1'b0;
        wr_q    <= 1'b0;
        oval_q  <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= 2'd2;
      end else begin
        case (state_q)
          S_IDLE: begin
            abort_q <= 1'b0;
            if (start) begin
              err_q <= 2'd0;
              if (num_entries == 16'd0) begin
                done_q <= 1'b1;
              end else begin
                idx_q   <= first_idx;
                cnt_q   <= num_entries;
                sel_q   <= 1'b1;
                wr_q    <= 1'b0;
                addr_q  <= ADDR_IDX;
                state_q <= S_RD_IDX;
              end
            end
          end
          S_RD_IDX: if (m_ack) begin
            c_q     <= m_rdata;
            sel_q   <= 1'b0;
            state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (range_bad) begin
              done_q  <= 1'b1;
              err_q   <= 2'd1;
              state_q <= S_IDLE;
            end else begin
              sel_q   <= 1'b1;
              wr_q    <= 1'b1;
              addr_q  <= ADDR_RDA;
              wdata_q <= ring_cur;
              state_q <= S_SET_ADDR;
            end
          end
          S_SET_ADDR: if (m_ack) begin
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            sel_q   <= 1'b1;
            addr_q  <= ADDR_D0;
            state_q <= S_RD_W0;
          end
          S_RD_W0: if (m_ack) begin
            odata_q[31:0] <= m_rdata;
            addr_q        <= ADDR_D1;
            state_q       <= S_RD_W1;
          end
          S_RD_W1: if (m_ack) begin
            odata_q[63:32] <= m_rdata;
            addr_q         <= ADDR_D2;
            state_q        <= S_RD_W2;
          end
          S_RD_W2: if (m_ack) begin
            odata_q[95:64] <= m_rdata;
            addr_q         <= ADDR_D3;
            state_q        <= S_RD_W3;
          end
          S_RD_W3: if (m_ack) begin
            odata_q[127:96] <= m_rdata;
            sel_q           <= 1'b0;
            oval_q          <= 1'b1;
            oidx_q          <= idx_q;
            state_q         <= S_EMIT;
          end
          S_EMIT: if (out_ready) begin
            oval_q <= 1'b0;
            idx_q  <= idx_nxt;
            cnt_q  <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              done_q  <= 1'b1;
              err_q   <= 2'd0;
              state_q <= S_IDLE;
            end else begin
              sel_q   <= 1'b1;
              wr_q    <= 1'b1;
              addr_q  <= ADDR_RDA;
              wdata_q <= ring_nxt;
              state_q <= S_SET_ADDR;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign m_sel     = sel_q;
  assign m_wr      = wr_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign out_valid = oval_q;
  assign out_data  = odata_q;
  assign out_index = oidx_q;

endmodule

// File: tb/tb_boreal_ledger_replay.sv
// Scoreboard bench for boreal_ledger_replay with a behavioural MMIO ledger slave.
module tb_boreal_ledger_replay;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  first_idx = '0;
  logic [15:0]  num_entries = '0;
  logic         abort = 1'b0;
  logic         busy, done, m_sel, m_wr, m_ack, out_valid;
  logic         out_ready = 1'b1;
  logic [1:0]   err;
  logic [31:0]  m_addr, m_wdata, m_rdata, out_index;
  logic [127:0] out_data;

  always #5 clk = ~clk;

  boreal_ledger_replay #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DEPTH_LOG(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx),
    .num_entries(num_entries), .abort(abort), .busy(busy), .done(done), .err(err),
    .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_ready(out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ledger slave: programmable ack delay, RD_DATA words derived from RD_ADDR
  int          ack_dly = 0;
  int          wcnt = 0;
  logic [31:0] c_val = '0;
  logic [31:0] rd_addr_r = '0;

  function automatic logic [31:0] lw(input logic [31:0] a, input int k);
    return {8'(k + 1), 8'h3C, a[15:0]};
  endfunction

  assign m_ack = m_sel && (wcnt == ack_dly);

  always_comb begin
    m_rdata = 32'hDEAD_BEEF;
    case (m_addr - BASE)
      32'h00: m_rdata = c_val;
      32'h08: m_rdata = rd_addr_r;
      32'h0C: m_rdata = lw(rd_addr_r, 0);
      32'h10: m_rdata = lw(rd_addr_r, 1);
      32'h14: m_rdata = lw(rd_addr_r, 2);
      32'h18: m_rdata = lw(rd_addr_r, 3);
      default: m_rdata = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (m_sel && !m_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (rst_n && m_sel && m_ack && m_wr && (m_addr == BASE + 32'h08))
      rd_addr_r <= m_wdata;
  end

  // Consumer: hold out_ready low for rdy_lat cycles of every offered entry
  int rdy_lat = 0;
  int rcnt = 0;
  initial forever begin
    @(posedge clk); #1;
    if (!out_valid) begin
      rcnt = 0;
      out_ready = (rdy_lat == 0);
    end else begin
      rcnt++;
      if (rcnt > rdy_lat) out_ready = 1'b1;
    end
  end

  // Scoreboard and monitor
  logic [31:0]  exp_idx_q[$];
  logic [127:0] exp_dat_q[$];
  logic [31:0]  exp_wd_q[$];
  logic [1:0]   exp_err_q[$];
  int           xfer_rel_q[$];
  int           cyc = 0, t0 = 0, done_cnt = 0, done_rel = 0, ack_cnt = 0, sel_cnt = 0;
  logic         pv = 0, pr = 0, ps = 0, pa = 0, pwr = 0;
  logic [127:0] pd = '0;
  logic [31:0]  pi = '0, paddr = '0, pwd = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
      ps = 0;
    end else begin
      if (pv && !pr) begin
        chk("valid_hold", out_valid, 1);
        chk("data_hold", out_data, pd);
        chk("index_hold", out_index, pi);
      end
      if (ps && !pa) begin
        chk("req_sel_hold", m_sel, 1);
        chk("req_addr_hold", m_addr, paddr);
        chk("req_wr_hold", m_wr, pwr);
        chk("req_wdata_hold", m_wdata, pwd);
      end
      if (m_sel) sel_cnt++;
      if (m_sel && m_ack) begin
        ack_cnt++;
        if (m_wr) begin
          chk("wr_addr", m_addr, BASE + 32'h08);
          if (exp_wd_q.size() == 0) chk("wdata_unexpected", m_wr, 0);
          else chk("rd_addr_wdata", m_wdata, exp_wd_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        xfer_rel_q.push_back(cyc - t0);
        if (exp_idx_q.size() == 0) chk("xfer_unexpected", out_valid, 0);
        else begin
          chk("out_index", out_index, exp_idx_q.pop_front());
          chk("out_data", out_data, exp_dat_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
        if (exp_err_q.size() == 0) chk("done_unexpected", done, 0);
        else chk("done_err", err, exp_err_q.pop_front());
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_index;
      ps = m_sel; pa = m_ack; paddr = m_addr; pwr = m_wr; pwd = m_wdata;
    end
  end

  task automatic do_start(input logic [31:0] f, input logic [15:0] n, input bit will_abort);
    logic [32:0] s;
    logic [1:0]  e;
    logic [31:0] ix, ra;
    @(posedge clk); #1;
    s = {1'b0, f} + 33'(n);
    e = 2'd0;
    if (n != 0 && ((s > {1'b0, c_val}) ||
        ((c_val > 32'(DEPTH)) && (f < c_val - 32'(DEPTH))))) e = 2'd1;
    if (will_abort) begin
      e = 2'd2;
      exp_wd_q.push_back(f & 32'(DEPTH - 1));
    end else if (e == 2'd0) begin
      for (int i = 0; i < int'(n); i++) begin
        ix = f + 32'(i);
        ra = ix & 32'(DEPTH - 1);
        exp_idx_q.push_back(ix);
        exp_dat_q.push_back({lw(ra, 3), lw(ra, 2), lw(ra, 1), lw(ra, 0)});
        exp_wd_q.push_back(ra);
      end
    end
    exp_err_q.push_back(e);
    xfer_rel_q.delete();
    ack_cnt = 0;
    sel_cnt = 0;
    t0 = cyc;
    first_idx = f;
    num_entries = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic poke_start(input logic [31:0] f, input logic [15:0] n);
    @(posedge clk); #1;
    first_idx = f;
    num_entries = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 32'(done_cnt != d0), 1);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sel"}, m_sel, 0);
    chk({tag, "_wr"}, m_wr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_addr"}, m_addr, 0);
    chk({tag, "_wdata"}, m_wdata, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int dsave;
    repeat (3) @(negedge clk);
    chk_zero_outs("por");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Nominal replay: timing of first entry, entry period and done
    c_val = 32'd5;
    do_start(32'd1, 16'd3, 0);
    wait_done(100);
    chk("t1_xfer_count", xfer_rel_q.size(), 3);
    for (int i = 0; i < xfer_rel_q.size() && i < 3; i++)
      chk("t1_xfer_cycle", xfer_rel_q[i], 9 + 7 * i);
    chk("t1_done_cycle", done_rel, 24);
    chk("t1_sb_empty", exp_idx_q.size(), 0);

    // Window past the committed count
    do_start(32'd4, 16'd2, 0);
    wait_done(50);
    chk("t2_acks", ack_cnt, 1);
    chk("t2_no_xfer", xfer_rel_q.size(), 0);
    chk("t2_err_hold", err, 1);

    // Ring wrap-around window limits
    c_val = 32'd1030;
    do_start(32'd6, 16'd2, 0);
    wait_done(100);
    chk("t3_xfer_count", xfer_rel_q.size(), 2);
    do_start(32'd5, 16'd2, 0);
    wait_done(50);
    chk("t3b_no_xfer", xfer_rel_q.size(), 0);

    // Slow slave and stalled consumer; a start while busy and a moving IDX
    c_val = 32'd20;
    ack_dly = 2;
    rdy_lat = 4;
    do_start(32'd10, 16'd3, 0);
    repeat (4) @(posedge clk);
    poke_start(32'd0, 16'd5);
    c_val = 32'd11;
    wait_done(400);
    chk("t4_xfer_count", xfer_rel_q.size(), 3);
    chk("t4_sb_empty", exp_idx_q.size(), 0);
    ack_dly = 0;
    rdy_lat = 0;

    // Empty replay
    do_start(32'd3, 16'd0, 0);
    wait_done(10);
    chk("t5_done_cycle", done_rel, 1);
    chk("t5_no_mmio", sel_cnt, 0);

    // Abort while RD_DATA2 is outstanding
    c_val = 32'd20;
    ack_dly = 2;
    do_start(32'd2, 16'd1, 1);
    k = 0;
    while (!(m_sel && m_addr == BASE + 32'h14) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_w2_reached", m_addr, BASE + 32'h14);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(50);
    chk("t6_acks", ack_cnt, 5);
    chk("t6_no_xfer", xfer_rel_q.size(), 0);
    @(negedge clk);
    chk("t6_err_hold", err, 2);
    chk("t6_idle", busy, 0);
    ack_dly = 0;

    // Reset in the middle of a replay, then a fresh replay
    do_start(32'd2, 16'd3, 0);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outs("rst_mid");
    exp_idx_q.delete();
    exp_dat_q.delete();
    exp_wd_q.delete();
    exp_err_q.delete();
    dsave = done_cnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t7_no_done", done_cnt, dsave);
    do_start(32'd0, 16'd2, 0);
    wait_done(100);
    chk("t7_xfer_count", xfer_rel_q.size(), 2);
    chk("t7_first_cycle", (xfer_rel_q.size() > 0) ? xfer_rel_q[0] : -1, 9);
    chk("t7_sb_empty", exp_idx_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
